sm_accum: RTL

Sequential sign-magnitude accumulator: takes a stream of 16-bit sign-magnitude terms and converts each one to two's complement. It sums a configurable number of consecutive terms into a wide saturating accumulator and returns each group total through a valid/ready handshake. It sits downstream of the CiM sign-generation stage and rebuilds signed partial sums from the magnitude/sign pairs that stage produces.

---
 rtl/sm_accum.sv | 132 +++++++++++++
 1 files changed

// File: rtl/sm_accum.sv
// sm_accum: sign-magnitude term accumulator.
// Converts each sign-magnitude term to two's complement and sums groups of
// cfg_len terms into a saturating accumulator. Each group total is returned
// through a valid/ready handshake.
module sm_accum #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 24,
    parameter int LEN_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [LEN_W-1:0]        cfg_len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_magnitude,
    input  logic                    in_sign,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_data,
    output logic                    out_sat,
    output logic                    busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCUM  = 2'd1;
    localparam logic [1:0] OUTPUT = 2'd2;

    logic [1:0]              state;
    logic signed [ACC_W-1:0] acc;
    logic [LEN_W-1:0]        cnt;
    logic [LEN_W-1:0]        len;
    logic                    sat;

    logic                    accept;
    logic signed [ACC_W-1:0] term;
    logic [ACC_W:0]          add_r;
    logic [LEN_W-1:0]        first_len;
    logic [LEN_W-1:0]        cnt_nxt;

    // Sign-magnitude to two's complement; negative zero naturally maps to 0.
    function automatic logic signed [ACC_W-1:0] to_term(
        input logic [DATA_W-1:0] mag,
        input logic              neg
    );
        logic signed [DATA_W:0] t;
        t = $signed({1'b0, mag});
        if (neg) begin
            t = -t;
        end
        return ACC_W'(t);
    endfunction

    // Saturating add. Result bit ACC_W flags that clamping happened;
    // the low ACC_W bits are the (possibly clamped) sum.
    function automatic logic [ACC_W:0] sat_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
        logic signed [ACC_W:0] s;
        logic [ACC_W:0]        r;
        s = (ACC_W+1)'(a) + (ACC_W+1)'(b);
        if (s[ACC_W] != s[ACC_W-1]) begin
            r[ACC_W] = 1'b1;
            if (s[ACC_W]) begin
                r[ACC_W-1:0] = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                r[ACC_W-1:0] = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end else begin
            r = {1'b0, s[ACC_W-1:0]};
        end
        return r;
    endfunction

    // Output and ready signals are pure decodes of the registered state,
    // so in_ready never depends combinationally on out_ready.
    always_comb begin
        in_ready  = (state == IDLE) || (state == ACCUM);
        out_valid = (state == OUTPUT);
        busy      = (state != IDLE);
        out_data  = acc;
        out_sat   = sat;
        accept    = in_valid && in_ready;
        term      = to_term(in_magnitude, in_sign);
        add_r     = sat_add(acc, term);
        first_len = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
        cnt_nxt   = cnt + LEN_W'(1);
    end

    // Group FSM: first beat latches the length, later beats accumulate,
    // OUTPUT holds the result until the downstream handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            len   <= '0;
            sat   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        len   <= first_len;
                        acc   <= term;
                        sat   <= 1'b0;
                        cnt   <= LEN_W'(1);
                        state <= (first_len == LEN_W'(1)) ? OUTPUT : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc <= $signed(add_r[ACC_W-1:0]);
                        sat <= sat | add_r[ACC_W];
                        cnt <= cnt_nxt;
                        if (cnt_nxt == len) begin
                            state <= OUTPUT;
                        end
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
